// File: rtl/tx_frame_sequencer_pkg.sv
// Shared types and defaults for the serial transmit frame sequencer.
package tx_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txseq_state_e;

  localparam int unsigned DEF_DIV       = 10;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_STOP_BITS = 1;
  localparam logic        IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/bit_tick_divider.sv
// Restartable modulo-DIV counter; tick marks the last clock of each bit period.
module bit_tick_divider
  import tx_frame_sequencer_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign tick   = en && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || !en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Serial transmit framer: start, DATA_W bits LSB first, optional parity, stop bit(s).
// Optional even parity bit enabled by defining TXSEQ_PARITY_EN.
module tx_frame_sequencer
  import tx_frame_sequencer_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned STOP_BITS = DEF_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BW = $clog2(DATA_W + STOP_BITS);

  txseq_state_e      r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_idx;
  logic              r_tx_out;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_frame_done;
`ifdef TXSEQ_PARITY_EN
  logic              r_parity;
`endif

  logic              w_accept;
  logic              w_div_en;
  logic              w_tick;
  logic [DATA_W-1:0] w_shift_next;

  assign w_accept     = tx_valid && r_tx_ready;
  assign w_div_en     = (r_state != IDLE);
  assign w_shift_next = r_shift >> 1;

  assign tx_ready   = r_tx_ready;
  assign tx_out     = r_tx_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  bit_tick_divider #(.DIV(DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (w_accept),
    .en      (w_div_en),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_tx_out     <= IDLE_LEVEL;
      r_tx_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef TXSEQ_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= tx_data;
            r_bit_idx  <= '0;
            r_tx_out   <= ~IDLE_LEVEL;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START;
`ifdef TXSEQ_PARITY_EN
            // Parity is taken at acceptance because the shift register is consumed.
            r_parity   <= ^tx_data;
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx_out  <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_idx == BW'(DATA_W - 1)) begin
              r_bit_idx <= '0;
`ifdef TXSEQ_PARITY_EN
              r_state   <= PARITY;
              r_tx_out  <= r_parity;
`else
              r_state   <= STOP;
              r_tx_out  <= IDLE_LEVEL;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx_out  <= w_shift_next[0];
            end
          end
        end
`ifdef TXSEQ_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state  <= STOP;
            r_tx_out <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_bit_idx == BW'(STOP_BITS - 1)) begin
              r_bit_idx    <= '0;
              r_state      <= IDLE;
              r_tx_ready   <= 1'b1;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_out   <= IDLE_LEVEL;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer against a bit-level line model.
module tb_tx_frame_sequencer;

  localparam int unsigned DIV       = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STOP_BITS = 1;
`ifdef TXSEQ_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS     = 1 + DATA_W + P + STOP_BITS;
  localparam int unsigned FRAME_CYC = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_frame_sequencer #(
    .DIV       (DIV),
    .DATA_W    (DATA_W),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Expected line level at clock 'cyc' after acceptance: bit slot = cyc / DIV.
  function automatic logic exp_line(input logic [7:0] b, input int unsigned cyc);
    int unsigned k;
    int unsigned ones;
    k    = cyc / DIV;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= DATA_W) return b[k-1];
    if (P == 1 && k == DATA_W + 1) begin
      for (int unsigned i = 0; i < DATA_W; i++) ones += int'(b[i]);
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  // Entered at a negedge with tx_valid=1 and tx_data=b already driven; returns at
  // the negedge of the frame_done cycle.
  task automatic run_frame(input string nm, input logic [7:0] b, input bit keep_valid,
                           input bit scramble, input int unsigned chg_at,
                           input logic [7:0] next_b);
    logic e;
    for (int unsigned c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      if (c == 0 && !keep_valid) tx_valid = 1'b0;
      e = exp_line(b, c);
      n_vec++;
      if (tx_out !== e) begin
        n_err++;
        $display("FAIL %s tx_out byte %02h cyc %0d: got %b want %b", nm, b, c, tx_out, e);
      end
      n_vec++;
      if (busy !== 1'b1 || tx_ready !== 1'b0 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s ctrl cyc %0d: busy/ready/done got %b%b%b want 100",
                 nm, c, busy, tx_ready, frame_done);
      end
      if (c == chg_at) tx_data = next_b;
      else if (scramble && c < chg_at) tx_data = 8'($urandom);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_out !== 1'b1) begin
      n_err++;
      $display("FAIL %s end: done/busy/ready/tx_out got %b%b%b%b want 1011",
               nm, frame_done, busy, tx_ready, tx_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: tx_out/ready/busy/done got %b%b%b%b want 1100",
               tx_out, tx_ready, busy, frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle(input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      n_vec++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL idle cyc %0d: tx_out/ready/busy/done got %b%b%b%b want 1100",
                 c, tx_out, tx_ready, busy, frame_done);
      end
    end
  endtask

  task automatic test_known_bytes();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hA5;
    run_frame("byteA5", 8'hA5, 1'b0, 1'b0, FRAME_CYC - 1, 8'h00);
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL after_A5: done/busy/ready got %b%b%b want 001", frame_done, busy, tx_ready);
    end
    tx_valid = 1'b1; tx_data = 8'h01;
    run_frame("byte01", 8'h01, 1'b0, 1'b0, FRAME_CYC - 1, 8'h00);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h3C;
    run_frame("b2b_3C", 8'h3C, 1'b1, 1'b0, 0, 8'hC3);
    run_frame("b2b_C3", 8'hC3, 1'b0, 1'b0, FRAME_CYC - 1, 8'h00);
  endtask

  task automatic test_data_change();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h55;
    run_frame("chg_55", 8'h55, 1'b1, 1'b0, 20, 8'hAA);
    run_frame("chg_AA", 8'hAA, 1'b0, 1'b0, FRAME_CYC - 1, 8'h00);
  endtask

  task automatic test_reset_mid(input string nm, input logic [7:0] b, input int unsigned at);
    logic e;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = b;
    for (int unsigned c = 0; c <= at; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      e = exp_line(b, c);
      n_vec++;
      if (tx_out !== e) begin
        n_err++;
        $display("FAIL %s pre tx_out cyc %0d: got %b want %b", nm, c, tx_out, e);
      end
    end
    rst = 1'b1; tx_valid = 1'b1; tx_data = ~b;
    #1;
    n_vec++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s async: tx_out/busy/ready/done got %b%b%b%b want 1010",
               nm, tx_out, busy, tx_ready, frame_done);
    end
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s in_rst cyc %0d: tx_out/busy/ready/done got %b%b%b%b want 1010",
                 nm, c, tx_out, busy, tx_ready, frame_done);
      end
    end
    rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h00;
    run_frame({nm, "_post"}, 8'h00, 1'b0, 1'b1, FRAME_CYC - 1, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0]  bytes [16];
    int unsigned gap   [16];
    bit          b2b;
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom);
      gap[i]   = $urandom_range(0, 3);
    end
    @(negedge clk);
    tx_valid = 1'b1; tx_data = bytes[0];
    for (int i = 0; i < 16; i++) begin
      b2b = (i < 15) && (gap[i] == 0);
      run_frame("rand", bytes[i], b2b, 1'b1, FRAME_CYC - 1, b2b ? bytes[(i + 1) % 16] : 8'h00);
      if (!b2b) begin
        for (int unsigned g = 0; g < gap[i]; g++) begin
          @(negedge clk);
          n_vec++;
          if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rand gap %0d: tx_out/busy/ready/done got %b%b%b%b want 1010",
                     i, tx_out, busy, tx_ready, frame_done);
          end
        end
        if (i < 15) begin
          if (gap[i] == 0) @(negedge clk);
          tx_valid = 1'b1; tx_data = bytes[i + 1];
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle(200);
    test_known_bytes();
    test_back_to_back();
    test_data_change();
    test_reset_mid("rst_FF", 8'hFF, 35);
    test_reset_mid("rst_00", 8'h00, 35);
    test_random();
    test_idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
